// File: rtl/segment_value_sampler_if.sv
// Segment-to-value handshake bundle for the segment value sampler.
// master: segment producer (drives in_*); slave: sampler (drives out_*).
interface segment_value_sampler_if #(
  parameter int WIDTH = 32
);
  logic                    in_enable;
  logic                    in_seed_load;
  logic [31:0]             in_seed;
  logic                    in_segment_valid;
  logic [1:0]              in_segment_type;
  logic signed [WIDTH-1:0] in_segment_from;
  logic signed [WIDTH-1:0] in_segment_to;
  logic                    out_ready;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_value;
  logic                    out_timeout;
  logic                    out_error;

  modport master (
    output in_enable,
    output in_seed_load,
    output in_seed,
    output in_segment_valid,
    output in_segment_type,
    output in_segment_from,
    output in_segment_to,
    input  out_ready,
    input  out_valid,
    input  out_value,
    input  out_timeout,
    input  out_error
  );

  modport slave (
    input  in_enable,
    input  in_seed_load,
    input  in_seed,
    input  in_segment_valid,
    input  in_segment_type,
    input  in_segment_from,
    input  in_segment_to,
    output out_ready,
    output out_valid,
    output out_value,
    output out_timeout,
    output out_error
  );
endinterface

// File: rtl/segment_value_sampler.sv
// Draws a signed value inside one chosen segment using a 32-bit LFSR.
// Uniform segments: rejection sampling against a power-of-two mask.
// Exponential segments: geometric walk (p=1/2) from the heavy end.
// Ports:
//   in_clock  - rising-edge clock
//   in_reset  - asynchronous active-high reset
//   bus       - slave side of segment_value_sampler_if:
//     in_enable, in_seed_load, in_seed, in_segment_valid/type/from/to
//     out_ready, out_valid, out_value, out_timeout, out_error
module segment_value_sampler #(
  parameter int WIDTH     = 32,
  parameter int MAX_TRIES = 64
) (
  input logic                    in_clock,
  input logic                    in_reset,
  segment_value_sampler_if.slave bus
);

  localparam logic [31:0] TAPS = 32'h80200003;
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
  localparam logic [TW-1:0] TRY_ONE  = TW'(1);
  localparam logic [WIDTH:0] ONE_W1  = (WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UNIFORM,
    S_GEOM
  } state_t;

  state_t                  state_q;
  logic [31:0]             lfsr_q;
  logic [1:0]              type_q;
  logic signed [WIDTH-1:0] from_q;
  logic signed [WIDTH-1:0] to_q;
  logic [WIDTH:0]          range_q;
  logic [WIDTH-1:0]        mask_q;
  logic [TW-1:0]           tries_q;
  logic [WIDTH:0]          k_q;
  logic                    valid_q;
  logic                    timeout_q;
  logic                    error_q;
  logic signed [WIDTH-1:0] value_q;

  logic [31:0]             lfsr_d;
  logic [31:0]             seed_d;
  logic [WIDTH:0]          span_d;
  logic [WIDTH:0]          range_d;
  logic [WIDTH-1:0]        mask_d;
  logic                    smear;
  logic                    bad_d;
  logic                    ready_d;
  logic                    accept_d;
  logic [WIDTH-1:0]        cand_d;
  logic                    cand_ok_d;
  logic [WIDTH:0]          k_inc_d;
  logic                    restart_d;
  logic signed [WIDTH-1:0] geom_val_d;
  logic signed [WIDTH-1:0] fall_d;
  logic signed [WIDTH-1:0] uni_val_d;

  // Incoming segment decode: range in WIDTH+1 bits so a full-span
  // segment (2^WIDTH values) is still representable.
  always_comb begin
    span_d = {bus.in_segment_to[WIDTH-1], bus.in_segment_to}
           - {bus.in_segment_from[WIDTH-1], bus.in_segment_from};
    range_d = span_d + ONE_W1;
    bad_d = (bus.in_segment_type == 2'd3)
         || ($signed(bus.in_segment_from) > $signed(bus.in_segment_to));
    mask_d = '0;
    smear  = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      smear     = smear | span_d[i];
      mask_d[i] = smear;
    end
  end

  // LFSR next state and seed sanitising (all-zero would lock up).
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
    seed_d = (bus.in_seed == 32'h0) ? 32'h1 : bus.in_seed;
  end

  // Draw datapath, all based on the pre-advance LFSR value.
  always_comb begin
    cand_d     = lfsr_q[WIDTH-1:0] & mask_q;
    cand_ok_d  = {1'b0, cand_d} < range_q;
    uni_val_d  = from_q + cand_d;
    k_inc_d    = k_q + ONE_W1;
    restart_d  = (k_inc_d == range_q);
    geom_val_d = (type_q == 2'd1) ? (to_q - k_q[WIDTH-1:0])
                                  : (from_q + k_q[WIDTH-1:0]);
    fall_d     = (type_q == 2'd1) ? to_q : from_q;
  end

  // A result still on out_valid blocks acceptance for one cycle.
  always_comb begin
    ready_d  = (state_q == S_IDLE) && !valid_q && bus.in_enable;
    accept_d = ready_d && bus.in_segment_valid;
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q   <= S_IDLE;
      lfsr_q    <= 32'h1;
      type_q    <= 2'd0;
      from_q    <= '0;
      to_q      <= '0;
      range_q   <= '0;
      mask_q    <= '0;
      tries_q   <= '0;
      k_q       <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
      value_q   <= '0;
    end else if (bus.in_enable) begin
      lfsr_q    <= bus.in_seed_load ? seed_d : lfsr_d;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            type_q  <= bus.in_segment_type;
            from_q  <= bus.in_segment_from;
            to_q    <= bus.in_segment_to;
            range_q <= range_d;
            mask_q  <= mask_d;
            tries_q <= '0;
            k_q     <= '0;
            if (bad_d) begin
              valid_q <= 1'b1;
              error_q <= 1'b1;
              value_q <= bus.in_segment_from;
            end else if (bus.in_segment_type == 2'd0) begin
              state_q <= S_UNIFORM;
            end else begin
              state_q <= S_GEOM;
            end
          end
        end
        S_UNIFORM: begin
          if (cand_ok_d) begin
            value_q <= uni_val_d;
            valid_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (tries_q == TRY_LAST) begin
            value_q   <= from_q;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            tries_q <= tries_q + TRY_ONE;
          end
        end
        S_GEOM: begin
          if (lfsr_q[0]) begin
            value_q <= geom_val_d;
            valid_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (restart_d) begin
            // Walked past the light end: start the walk over.
            if (tries_q == TRY_LAST) begin
              value_q   <= fall_d;
              valid_q   <= 1'b1;
              timeout_q <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              tries_q <= tries_q + TRY_ONE;
              k_q     <= '0;
            end
          end else begin
            k_q <= k_inc_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.out_ready   = ready_d;
  assign bus.out_valid   = valid_q;
  assign bus.out_value   = value_q;
  assign bus.out_timeout = timeout_q;
  assign bus.out_error   = error_q;

endmodule

// File: tb/tb_segment_value_sampler.sv
// Directed bench for segment_value_sampler.
// Instance a: MAX_TRIES=64, instance b: MAX_TRIES=1, shared stimulus.
module tb_segment_value_sampler;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic sl;
  logic [31:0] seed;
  logic sv;
  logic [1:0] st;
  logic signed [W-1:0] sf;
  logic signed [W-1:0] stt;
  bit sel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  segment_value_sampler_if #(.WIDTH(W)) a_if ();
  segment_value_sampler_if #(.WIDTH(W)) b_if ();

  assign a_if.in_enable        = en;
  assign a_if.in_seed_load     = sl;
  assign a_if.in_seed          = seed;
  assign a_if.in_segment_valid = sv;
  assign a_if.in_segment_type  = st;
  assign a_if.in_segment_from  = sf;
  assign a_if.in_segment_to    = stt;
  assign b_if.in_enable        = en;
  assign b_if.in_seed_load     = sl;
  assign b_if.in_seed          = seed;
  assign b_if.in_segment_valid = sv;
  assign b_if.in_segment_type  = st;
  assign b_if.in_segment_from  = sf;
  assign b_if.in_segment_to    = stt;

  segment_value_sampler #(.WIDTH(W), .MAX_TRIES(64)) dut_a (
    .in_clock (clk),
    .in_reset (rst),
    .bus      (a_if)
  );

  segment_value_sampler #(.WIDTH(W), .MAX_TRIES(1)) dut_b (
    .in_clock (clk),
    .in_reset (rst),
    .bus      (b_if)
  );

  wire o_rdy = sel ? b_if.out_ready : a_if.out_ready;
  wire o_vld = sel ? b_if.out_valid : a_if.out_valid;
  wire o_tmo = sel ? b_if.out_timeout : a_if.out_timeout;
  wire o_err = sel ? b_if.out_error : a_if.out_error;
  wire signed [W-1:0] o_val = sel ? b_if.out_value : a_if.out_value;

  task automatic settle();
    int g = 0;
    @(negedge clk);
    while (!(a_if.out_ready && b_if.out_ready) && g < 200) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic seed_load(input logic [31:0] s);
    @(negedge clk);
    sl = 1'b1;
    seed = s;
    @(negedge clk);
    sl = 1'b0;
  endtask

  // Presents a segment at the current negedge; lat counts edges from
  // the accept edge up to the edge that raised out_valid.
  task automatic draw(input logic [1:0] t,
                      input logic signed [W-1:0] f,
                      input logic signed [W-1:0] to,
                      input int stall_at, input int stall_len,
                      output int lat, output logic signed [W-1:0] v,
                      output logic tmo, output logic er, output bit got);
    int g = 0;
    while (!o_rdy && g < 300) begin
      @(negedge clk);
      g++;
    end
    sv = 1'b1;
    st = t;
    sf = f;
    stt = to;
    @(negedge clk);
    sv = 1'b0;
    lat = 1;
    while (!o_vld && lat < 300) begin
      if (lat == stall_at && stall_len > 0) begin
        en = 1'b0;
        repeat (stall_len) @(negedge clk);
        lat += stall_len;
        en = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    got = o_vld;
    v = o_val;
    tmo = o_tmo;
    er = o_err;
  endtask

  task automatic test_reset();
    int lat;
    logic signed [W-1:0] v;
    logic tmo, er;
    bit got;
    sel = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (o_vld !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %0b want 0", o_vld);
    end
    n_cmp++;
    if (o_val !== 0) begin
      n_bad++; $display("FAIL reset_value: got %0d want 0", o_val);
    end
    n_cmp++;
    if (o_tmo !== 1'b0 || o_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: got %0b%0b want 00", o_tmo, o_err);
    end
    n_cmp++;
    if (o_rdy !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %0b want 1", o_rdy);
    end
    n_cmp++;
    if (dut_a.lfsr_q !== 32'h1) begin
      n_bad++; $display("FAIL reset_lfsr: got %h want 1", dut_a.lfsr_q);
    end
    rst = 1'b0;
    draw(2'd0, 2, 10, 0, 0, lat, v, tmo, er, got);
    n_cmp++;
    if (!got || v !== 5 || lat !== 2) begin
      n_bad++;
      $display("FAIL post_reset_draw: got v=%0d lat=%0d ok=%0b want 5/2/1",
               v, lat, got);
    end
  endtask

  task automatic test_seed_uniform();
    int lat;
    logic signed [W-1:0] v;
    logic tmo, er;
    bit got;
    sel = 1'b0;
    settle();
    seed_load(32'h1);
    draw(2'd0, 2, 10, 0, 0, lat, v, tmo, er, got);
    n_cmp++;
    if (!got || v !== 5 || lat !== 2 || tmo !== 1'b0) begin
      n_bad++;
      $display("FAIL seed1_uniform: got v=%0d lat=%0d tmo=%0b want 5/2/0",
               v, lat, tmo);
    end
    settle();
    seed_load(32'h0);
    draw(2'd0, 2, 10, 0, 0, lat, v, tmo, er, got);
    n_cmp++;
    if (!got || v !== 5 || lat !== 2) begin
      n_bad++;
      $display("FAIL seed0_uniform: got v=%0d lat=%0d want 5/2", v, lat);
    end
    settle();
    seed_load(32'h1E);
    draw(2'd0, 2, 10, 0, 0, lat, v, tmo, er, got);
    n_cmp++;
    if (!got || v !== 6 || lat !== 3 || tmo !== 1'b0) begin
      n_bad++;
      $display("FAIL reject_once: got v=%0d lat=%0d tmo=%0b want 6/3/0",
               v, lat, tmo);
    end
  endtask

  task automatic test_error();
    int lat;
    logic signed [W-1:0] v;
    logic tmo, er;
    bit got;
    sel = 1'b0;
    settle();
    draw(2'd3, 7, 9, 0, 0, lat, v, tmo, er, got);
    n_cmp++;
    if (!got || er !== 1'b1 || v !== 7 || lat !== 1 || tmo !== 1'b0) begin
      n_bad++;
      $display("FAIL type3_error: got v=%0d lat=%0d err=%0b want 7/1/1",
               v, lat, er);
    end
    @(negedge clk);
    n_cmp++;
    if (o_rdy !== 1'b1 || o_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL type3_idle: got rdy=%0b vld=%0b want 1/0", o_rdy, o_vld);
    end
    draw(2'd0, 10, 2, 0, 0, lat, v, tmo, er, got);
    n_cmp++;
    if (!got || er !== 1'b1 || v !== 10 || lat !== 1) begin
      n_bad++;
      $display("FAIL order_error: got v=%0d lat=%0d err=%0b want 10/1/1",
               v, lat, er);
    end
    @(negedge clk);
    n_cmp++;
    if (o_rdy !== 1'b1) begin
      n_bad++; $display("FAIL order_idle: got rdy=%0b want 1", o_rdy);
    end
  endtask

  task automatic test_degenerate();
    int lat;
    logic signed [W-1:0] v;
    logic tmo, er;
    bit got;
    int bad = 0;
    sel = 1'b0;
    settle();
    for (int i = 0; i < 20; i++) begin
      draw(2'd0, 5, 5, 0, 0, lat, v, tmo, er, got);
      if (!got || v !== 5 || lat !== 2) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL degenerate_uniform: got %0d bad draws want 0", bad);
    end
  endtask

  task automatic test_geom_hand();
    int lat;
    logic signed [W-1:0] v;
    logic tmo, er;
    bit got;
    sel = 1'b0;
    settle();
    seed_load(32'h4);
    draw(2'd1, 0, 8, 0, 0, lat, v, tmo, er, got);
    n_cmp++;
    if (!got || v !== 7 || lat !== 3) begin
      n_bad++;
      $display("FAIL exp_up_seed4: got v=%0d lat=%0d want 7/3", v, lat);
    end
    settle();
    seed_load(32'h1);
    draw(2'd2, -128, -120, 0, 0, lat, v, tmo, er, got);
    n_cmp++;
    if (!got || v !== -128 || lat !== 2) begin
      n_bad++;
      $display("FAIL exp_down_seed1: got v=%0d lat=%0d want -128/2", v, lat);
    end
  endtask

  task automatic test_timeout();
    int lat;
    logic signed [W-1:0] v;
    logic tmo, er;
    bit got;
    sel = 1'b1;
    settle();
    seed_load(32'h1E);
    draw(2'd0, 2, 10, 0, 0, lat, v, tmo, er, got);
    n_cmp++;
    if (!got || tmo !== 1'b1 || v !== 2 || lat !== 2) begin
      n_bad++;
      $display("FAIL uniform_timeout: got v=%0d tmo=%0b lat=%0d want 2/1/2",
               v, tmo, lat);
    end
    settle();
    seed_load(32'h8);
    draw(2'd1, 3, 4, 0, 0, lat, v, tmo, er, got);
    n_cmp++;
    if (!got || tmo !== 1'b1 || v !== 4 || lat !== 3) begin
      n_bad++;
      $display("FAIL exp_up_timeout: got v=%0d tmo=%0b lat=%0d want 4/1/3",
               v, tmo, lat);
    end
    settle();
    seed_load(32'h8);
    draw(2'd2, 3, 4, 0, 0, lat, v, tmo, er, got);
    n_cmp++;
    if (!got || tmo !== 1'b1 || v !== 3) begin
      n_bad++;
      $display("FAIL exp_down_timeout: got v=%0d tmo=%0b want 3/1", v, tmo);
    end
    sel = 1'b0;
  endtask

  task automatic test_uniform_dist();
    int lat;
    logic signed [W-1:0] v;
    logic tmo, er;
    bit got;
    bit seen [9];
    int oob = 0, tmo_n = 0, miss = 0, minlat = 1000, nseen = 0;
    sel = 1'b0;
    foreach (seen[i]) seen[i] = 1'b0;
    settle();
    seed_load(32'h1);
    for (int i = 0; i < 1000; i++) begin
      draw(2'd0, 2, 10, 0, 0, lat, v, tmo, er, got);
      if (!got) miss++;
      else if (v < 2 || v > 10) oob++;
      else seen[int'(v) - 2] = 1'b1;
      if (tmo) tmo_n++;
      if (lat < minlat) minlat = lat;
    end
    foreach (seen[i]) if (seen[i]) nseen++;
    n_cmp++;
    if (miss !== 0 || oob !== 0) begin
      n_bad++;
      $display("FAIL uni_bounds: got miss=%0d oob=%0d want 0/0", miss, oob);
    end
    n_cmp++;
    if (nseen !== 9) begin
      n_bad++; $display("FAIL uni_coverage: got %0d values want 9", nseen);
    end
    n_cmp++;
    if (tmo_n !== 0) begin
      n_bad++; $display("FAIL uni_timeouts: got %0d want 0", tmo_n);
    end
    n_cmp++;
    if (minlat < 2) begin
      n_bad++; $display("FAIL uni_latency: got min %0d want >=2", minlat);
    end
  endtask

  task automatic test_geom_dist(input logic [1:0] t,
                                input logic signed [W-1:0] f,
                                input logic signed [W-1:0] to);
    int lat;
    logic signed [W-1:0] v;
    logic tmo, er;
    bit got;
    int cnt [9];
    int oob = 0, h, c0, c1;
    sel = 1'b0;
    foreach (cnt[i]) cnt[i] = 0;
    settle();
    for (int i = 0; i < 2000; i++) begin
      draw(t, f, to, 0, 0, lat, v, tmo, er, got);
      if (!got || v < f || v > to) oob++;
      else begin
        h = (t == 2'd1) ? int'(to - v) : int'(v - f);
        cnt[h]++;
      end
    end
    c0 = cnt[0];
    c1 = cnt[1];
    n_cmp++;
    if (oob !== 0) begin
      n_bad++; $display("FAIL geom_bounds t%0d: got oob=%0d want 0", t, oob);
    end
    n_cmp++;
    if (c0 * 100 < c1 * 170 || c0 * 100 > c1 * 230) begin
      n_bad++;
      $display("FAIL geom_ratio t%0d: got heavy=%0d next=%0d want ~2x",
               t, c0, c1);
    end
  endtask

  task automatic test_full_range();
    int lat;
    logic signed [W-1:0] v;
    logic tmo, er;
    bit got;
    int oob = 0, tmo_n = 0, badfb = 0;
    sel = 1'b1;
    settle();
    for (int i = 0; i < 4096; i++) begin
      draw(2'd0, -128, 127, 0, 0, lat, v, tmo, er, got);
      if (!got || v < -128 || v > 127) oob++;
      if (tmo) begin
        tmo_n++;
        if (v !== -128) badfb++;
      end
    end
    n_cmp++;
    if (oob !== 0) begin
      n_bad++; $display("FAIL full_bounds: got oob=%0d want 0", oob);
    end
    n_cmp++;
    if (tmo_n !== 0 || badfb !== 0) begin
      n_bad++;
      $display("FAIL full_timeout: got tmo=%0d badfb=%0d want 0/0",
               tmo_n, badfb);
    end
    sel = 1'b0;
  endtask

  task automatic test_stall();
    int lat0, lat1, extra = 0;
    logic signed [W-1:0] v0, v1;
    logic tmo, er;
    bit got0, got1;
    sel = 1'b1;
    settle();
    seed_load(32'h12345678);
    draw(2'd0, -128, 127, 0, 0, lat0, v0, tmo, er, got0);
    n_cmp++;
    if (!got0 || v0 !== -68 || lat0 !== 2) begin
      n_bad++;
      $display("FAIL nostall_draw: got v=%0d lat=%0d want -68/2", v0, lat0);
    end
    settle();
    seed_load(32'h12345678);
    draw(2'd0, -128, 127, 1, 3, lat1, v1, tmo, er, got1);
    n_cmp++;
    if (!got1 || lat1 !== lat0 + 3 || v1 !== v0) begin
      n_bad++;
      $display("FAIL stall_draw: got v=%0d lat=%0d want %0d/%0d",
               v1, lat1, v0, lat0 + 3);
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (o_vld !== 1'b1 || o_val !== v1) begin
      n_bad++;
      $display("FAIL hold_valid: got vld=%0b v=%0d want 1/%0d", o_vld, o_val, v1);
    end
    en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_vld !== 1'b0) begin
      n_bad++; $display("FAIL hold_clear: got vld=%0b want 0", o_vld);
    end
    repeat (4) begin
      @(negedge clk);
      if (o_vld) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_bad++; $display("FAIL hold_dup: got %0d extra pulses want 0", extra);
    end
    sel = 1'b0;
  endtask

  task automatic test_ignore_busy();
    int extra = 0;
    sel = 1'b0;
    settle();
    seed_load(32'h1E);
    sv = 1'b1;
    st = 2'd0;
    sf = 2;
    stt = 10;
    @(negedge clk);
    st = 2'd3;
    sf = 100;
    stt = 0;
    n_cmp++;
    if (o_rdy !== 1'b0) begin
      n_bad++; $display("FAIL busy_ready: got %0b want 0", o_rdy);
    end
    @(negedge clk);
    sv = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_vld !== 1'b1 || o_val !== 6 || o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_result: got vld=%0b v=%0d err=%0b want 1/6/0",
               o_vld, o_val, o_err);
    end
    repeat (6) begin
      @(negedge clk);
      if (o_vld) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_bad++; $display("FAIL busy_queued: got %0d pulses want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic signed [W-1:0] v;
    logic tmo, er;
    bit got;
    sel = 1'b0;
    settle();
    seed_load(32'h1E);
    sv = 1'b1;
    st = 2'd0;
    sf = 2;
    stt = 10;
    @(negedge clk);
    sv = 1'b0;
    n_cmp++;
    if (o_rdy !== 1'b0) begin
      n_bad++; $display("FAIL mid_busy: got rdy=%0b want 0", o_rdy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (o_vld !== 1'b0 || o_val !== 0 || o_tmo !== 1'b0 || o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_out: got vld=%0b v=%0d want 0/0", o_vld, o_val);
    end
    n_cmp++;
    if (dut_a.lfsr_q !== 32'h1 || o_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_lfsr: got %h rdy=%0b want 1/1",
               dut_a.lfsr_q, o_rdy);
    end
    @(negedge clk);
    n_cmp++;
    if (o_vld !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_novalid: got %0b want 0", o_vld);
    end
    rst = 1'b0;
    draw(2'd0, 2, 10, 0, 0, lat, v, tmo, er, got);
    n_cmp++;
    if (!got || v !== 5 || lat !== 2) begin
      n_bad++;
      $display("FAIL mid_reset_next: got v=%0d lat=%0d want 5/2", v, lat);
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    sl = 1'b0;
    seed = 32'h0;
    sv = 1'b0;
    st = 2'd0;
    sf = 0;
    stt = 0;
    sel = 1'b0;
    test_reset();
    test_seed_uniform();
    test_error();
    test_degenerate();
    test_geom_hand();
    test_timeout();
    test_uniform_dist();
    test_geom_dist(2'd2, -128, -120);
    test_geom_dist(2'd1, 0, 8);
    test_full_range();
    test_stall();
    test_ignore_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
